// File: rtl/kb_div3_pkg.sv
// Shared definitions for the divide-by-3 / multiply-by-3 restore pair.
// Holds the FSM state type, the default word size and the remainder width.
package kb_div3_pkg;

    typedef enum logic {
        IDLE,
        SHIFT
    } kb_mul3_state_t;

    localparam int KB_DIV3_SIZE  = 20;
    localparam int KB_DIV3_REM_W = 2;

endpackage

// File: rtl/kb_mul3_restore_serial_if.sv
// Load/result bundle for kb_mul3_restore_serial.
// The mismatch signal exists only when KB_MUL3_SELFCHECK_EN is defined.
interface kb_mul3_restore_serial_if
    import kb_div3_pkg::*;
#(
    parameter int SIZE = KB_DIV3_SIZE
);
    logic                     load_en;
    logic [SIZE-1:0]          quotient;
    logic [KB_DIV3_REM_W-1:0] reminder;
    logic [SIZE-1:0]          divident;
    logic                     busy;
    logic                     valid;
    logic                     overflow;
`ifdef KB_MUL3_SELFCHECK_EN
    logic                     mismatch;
`endif

    modport master (
        output load_en, quotient, reminder,
`ifdef KB_MUL3_SELFCHECK_EN
        input  mismatch,
`endif
        input  divident, busy, valid, overflow
    );

    modport slave (
        input  load_en, quotient, reminder,
`ifdef KB_MUL3_SELFCHECK_EN
        output mismatch,
`endif
        output divident, busy, valid, overflow
    );

endinterface

// File: rtl/kb_mul3_restore_serial_bit_slice.sv
// One serial step of 3*q + r: adds the current bit, the previous bit (the 2*q
// term) and the running carry, producing one result bit and the next carry.
module kb_mul3_bit_slice
    import kb_div3_pkg::*;
(
    input  logic                     b,
    input  logic                     prev_bit,
    input  logic [KB_DIV3_REM_W-1:0] carry,
    output logic                     out_bit,
    output logic [KB_DIV3_REM_W-1:0] carry_next
);
    logic [2:0] sum;

    assign sum        = {2'b00, b} + {2'b00, prev_bit} + {1'b0, carry};
    assign out_bit    = sum[0];
    assign carry_next = sum[2:1];

endmodule

// File: rtl/kb_mul3_restore_serial.sv
// Bit-serial divident = 3*quotient + reminder, LSB first, SIZE cycles per word.
// Optional KB_MUL3_SELFCHECK_EN adds a parallel reference and a mismatch flag.
module kb_mul3_restore_serial
    import kb_div3_pkg::*;
#(
    parameter int SIZE = KB_DIV3_SIZE
) (
    input  logic                     sys_clock,
    input  logic                     reset,
    kb_mul3_restore_serial_if.slave  bus
);
    localparam int CNT_W = $clog2(SIZE);

    kb_mul3_state_t           state_reg, state_next;
    logic [SIZE-1:0]          operand_reg;
    logic [SIZE-1:0]          result_reg;
    logic [SIZE-1:0]          divident_reg;
    logic [KB_DIV3_REM_W-1:0] carry_reg;
    logic                     prev_bit_reg;
    logic [CNT_W-1:0]         bit_cnt_reg;
    logic                     valid_reg;
    logic                     overflow_reg;

    logic                     out_bit;
    logic [KB_DIV3_REM_W-1:0] carry_next;
    logic [1:0]               high_bits;
    logic [SIZE-1:0]          result_shifted;
    logic                     last_bit;
    logic                     load_accept;
    logic                     finish;

    kb_mul3_bit_slice u_slice (
        .b          (operand_reg[0]),
        .prev_bit   (prev_bit_reg),
        .carry      (carry_reg),
        .out_bit    (out_bit),
        .carry_next (carry_next)
    );

    assign last_bit       = (bit_cnt_reg == CNT_W'(SIZE - 1));
    assign result_shifted = {out_bit, result_reg[SIZE-1:1]};
    // Bits above SIZE: the final operand bit still owed to the 2*q term, plus carry.
    assign high_bits      = {1'b0, operand_reg[0]} + carry_next;

    always_ff @(posedge sys_clock) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next  = state_reg;
        load_accept = 1'b0;
        finish      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.load_en) begin
                    load_accept = 1'b1;
                    state_next  = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            operand_reg  <= '0;
            result_reg   <= '0;
            divident_reg <= '0;
            carry_reg    <= '0;
            prev_bit_reg <= 1'b0;
            bit_cnt_reg  <= '0;
            valid_reg    <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            valid_reg <= finish;
            if (load_accept) begin
                operand_reg  <= bus.quotient;
                carry_reg    <= bus.reminder;
                prev_bit_reg <= 1'b0;
                bit_cnt_reg  <= '0;
                result_reg   <= '0;
            end else if (state_reg == SHIFT) begin
                operand_reg  <= operand_reg >> 1;
                result_reg   <= result_shifted;
                carry_reg    <= carry_next;
                prev_bit_reg <= operand_reg[0];
                bit_cnt_reg  <= bit_cnt_reg + 1'b1;
            end
            if (finish) begin
                divident_reg <= result_shifted;
                overflow_reg <= |high_bits;
            end
        end
    end

    assign bus.divident = divident_reg;
    assign bus.busy     = (state_reg == SHIFT);
    assign bus.valid    = valid_reg;
    assign bus.overflow = overflow_reg;

`ifdef KB_MUL3_SELFCHECK_EN
    logic [SIZE+1:0] ref_reg;
    logic            mismatch_reg;

    always_ff @(posedge sys_clock) begin
        if (reset) begin
            ref_reg      <= '0;
            mismatch_reg <= 1'b0;
        end else begin
            if (load_accept)
                ref_reg <= {1'b0, bus.quotient, 1'b0} + {2'b00, bus.quotient}
                         + {{SIZE{1'b0}}, bus.reminder};
            if (finish)
                mismatch_reg <= ({high_bits, result_shifted} != ref_reg);
        end
    end

    assign bus.mismatch = mismatch_reg;

    a_no_mismatch : assert property (@(posedge sys_clock) disable iff (reset) !mismatch_reg);
`endif

endmodule

// File: tb/tb_kb_mul3_restore_serial.sv
// Directed-vector bench for kb_mul3_restore_serial: reset behaviour, a table of
// hand-computed results, the ignore/back-to-back/abort sequence and a round trip.
module tb_kb_mul3_restore_serial;
    import kb_div3_pkg::*;

    localparam int SIZE = KB_DIV3_SIZE;

    logic sys_clock = 1'b0;
    logic reset     = 1'b1;

    kb_mul3_restore_serial_if #(.SIZE(SIZE)) bus ();

    kb_mul3_restore_serial #(.SIZE(SIZE)) dut (
        .sys_clock (sys_clock),
        .reset     (reset),
        .bus       (bus)
    );

    always #5 sys_clock = ~sys_clock;

    typedef struct {
        logic [SIZE-1:0] quotient;
        logic [1:0]      reminder;
        logic [SIZE-1:0] exp_div;
        logic            exp_ovf;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Load at the next edge, then watch busy/valid through to completion.
    task automatic run_op(input logic [SIZE-1:0] q, input logic [1:0] r,
                          output logic [SIZE-1:0] d, output logic ovf, output logic lat_ok);
        lat_ok = 1'b1;
        @(negedge sys_clock);
        bus.load_en  = 1'b1;
        bus.quotient = q;
        bus.reminder = r;
        @(posedge sys_clock); #1;
        bus.load_en = 1'b0;
        if (bus.busy !== 1'b1 || bus.valid !== 1'b0) lat_ok = 1'b0;
        for (int k = 1; k < SIZE; k++) begin
            @(posedge sys_clock); #1;
            if (bus.busy !== 1'b1 || bus.valid !== 1'b0) lat_ok = 1'b0;
        end
        @(posedge sys_clock); #1;
        if (bus.busy !== 1'b0 || bus.valid !== 1'b1) lat_ok = 1'b0;
        d   = bus.divident;
        ovf = bus.overflow;
    endtask

    initial begin
        vec_t            vecs[7];
        logic [SIZE-1:0] d;
        logic [SIZE-1:0] dv;
        logic            ovf;
        logic            lat_ok;
        logic            seen;

        vecs[0] = '{20'd5,       2'd2, 20'd17,      1'b0};
        vecs[1] = '{20'h55555,   2'd0, 20'hFFFFF,   1'b0};
        vecs[2] = '{20'h55555,   2'd1, 20'h00000,   1'b1};
        vecs[3] = '{20'd0,       2'd3, 20'd3,       1'b0};
        vecs[4] = '{20'hFFFFF,   2'd0, 20'hFFFFD,   1'b1};
        vecs[5] = '{20'hFFFFF,   2'd3, 20'h00000,   1'b1};
        vecs[6] = '{20'd1,       2'd3, 20'd6,       1'b0};

        bus.load_en  = 1'b0;
        bus.quotient = '0;
        bus.reminder = '0;

        // Load pulse while reset is held must not start anything.
        repeat (2) @(posedge sys_clock);
        @(negedge sys_clock);
        bus.load_en  = 1'b1;
        bus.quotient = 20'd5;
        bus.reminder = 2'd2;
        @(posedge sys_clock); #1;
        bus.load_en = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(posedge sys_clock); #1;
            if (bus.busy !== 1'b0 || bus.valid !== 1'b0) seen = 1'b1;
        end
        check("reset_busy_valid", {31'd0, seen}, 32'd0);
        check("reset_divident", {12'd0, bus.divident}, 32'd0);
        check("reset_overflow", {31'd0, bus.overflow}, 32'd0);
        $display("reset: busy=%0b valid=%0b divident=0x%0h overflow=%0b",
                 bus.busy, bus.valid, bus.divident, bus.overflow);
        @(negedge sys_clock);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].quotient, vecs[i].reminder, dv, ovf, lat_ok);
            $display("vec %0d: q=0x%05h r=%0d -> divident=0x%05h overflow=%0b",
                     i, vecs[i].quotient, vecs[i].reminder, dv, ovf);
            check("vec_latency", {31'd0, lat_ok}, 32'd1);
            check("vec_divident", {12'd0, dv}, {12'd0, vecs[i].exp_div});
            check("vec_overflow", {31'd0, ovf}, {31'd0, vecs[i].exp_ovf});
        end

        // Ignored mid-run load, back-to-back load on the valid cycle, abort by reset.
        @(negedge sys_clock);
        bus.load_en  = 1'b1;
        bus.quotient = 20'd7;
        bus.reminder = 2'd0;
        @(posedge sys_clock); #1;            // T
        bus.load_en = 1'b0;
        repeat (4) @(posedge sys_clock);     // T+4
        @(negedge sys_clock);
        bus.load_en  = 1'b1;
        bus.quotient = 20'd100;
        bus.reminder = 2'd3;
        @(posedge sys_clock); #1;            // T+5
        bus.load_en = 1'b0;
        check("seq_busy_t5", {31'd0, bus.busy}, 32'd1);
        repeat (14) @(posedge sys_clock);    // T+19
        #1;
        check("seq_valid_t19", {31'd0, bus.valid}, 32'd0);
        @(posedge sys_clock); #1;            // T+20
        $display("seq: T+20 valid=%0b divident=%0d overflow=%0b",
                 bus.valid, bus.divident, bus.overflow);
        check("seq_valid_t20", {31'd0, bus.valid}, 32'd1);
        check("seq_divident_t20", {12'd0, bus.divident}, 32'd21);
        check("seq_overflow_t20", {31'd0, bus.overflow}, 32'd0);
        @(negedge sys_clock);
        bus.load_en  = 1'b1;
        bus.quotient = 20'd9;
        bus.reminder = 2'd1;
        @(posedge sys_clock); #1;            // T+21
        bus.load_en = 1'b0;
        check("seq_b2b_busy", {31'd0, bus.busy}, 32'd1);
        repeat (8) @(posedge sys_clock);     // T+29
        @(negedge sys_clock);
        reset = 1'b1;
        @(posedge sys_clock); #1;            // T+30
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_divident", {12'd0, bus.divident}, 32'd0);
        check("abort_overflow", {31'd0, bus.overflow}, 32'd0);
        @(negedge sys_clock);
        reset = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            @(posedge sys_clock); #1;
            if (bus.valid !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
        end
        check("abort_no_valid", {31'd0, seen}, 32'd0);
        $display("seq: abort done, divident=0x%0h busy=%0b", bus.divident, bus.busy);

        // Round trip against random dividends.
        for (int i = 0; i < 64; i++) begin
            d = SIZE'($urandom);
            run_op(d / 3, 2'(d % 3), dv, ovf, lat_ok);
            $display("rt %0d: d=0x%05h q=0x%05h r=%0d -> divident=0x%05h overflow=%0b",
                     i, d, d / 3, d % 3, dv, ovf);
            check("rt_latency", {31'd0, lat_ok}, 32'd1);
            check("rt_divident", {12'd0, dv}, {12'd0, d});
            check("rt_overflow", {31'd0, ovf}, 32'd0);
`ifdef KB_MUL3_SELFCHECK_EN
            check("rt_selfcheck", {31'd0, bus.mismatch}, 32'd0);
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
